// File: rtl/rxpack.sv
// rxpack: packs received frame bytes little-endian into 16-bit words (data from word 1, status in word 0).
// Optional feature macro RXPACK_RUNT_EN: frames under 60 bytes flag runt, skip rx_done_o and return to IDLE.
module rxpack #(
    parameter int unsigned MAXW = 1023
) (
    input  logic        eth_clk_i,
    input  logic        eth_rst_i,
    input  logic [7:0]  eth_rxd_i,
    input  logic        eth_rxv_i,
    input  logic        eth_sof_i,
    input  logic        eth_eof_i,
    input  logic        eth_err_i,
    input  logic        rx_ena_i,
    output logic [9:0]  eth_adr_o,
    output logic [15:0] eth_dat_o,
    output logic        eth_we_o,
    output logic        busy_o,
    output logic        rx_done_o,
    output logic [10:0] rx_len_o
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_DRAIN = 3'd2,
        S_STAT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [10:0] CNT_MAX = 11'(2 * MAXW);
    localparam logic [9:0]  ADR_MAX = 10'(MAXW);

    state_t      state_q, state_d;
    logic [9:0]  ptr_q, ptr_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  held_q, held_d;
    logic        odd_q, odd_d, ovf_q, ovf_d, err_q, err_d;
    logic [9:0]  adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic        we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic [10:0] len_q, len_d;
    logic        start_s, rcv_s, pend_s, data_we_s, stat_we_s, stat_vis_s, runt_s;
    logic [9:0]  wadr_s;
    logic [15:0] wdat_s, stat_word_s;

`ifdef RXPACK_RUNT_EN
    assign runt_s = (cnt_d < 11'd60);
`else
    assign runt_s = 1'b0;
`endif

    // Status word is on the outputs this cycle (data words never use address 0).
    assign stat_vis_s = (state_q == S_STAT) && we_q && (adr_q == 10'd0);

    // Byte acceptance, packing, overflow and end-of-frame drain decision.
    always_comb begin
        start_s   = (state_q == S_IDLE) && eth_sof_i && rx_ena_i;
        rcv_s     = start_s || (state_q == S_RECV);
        ptr_d     = start_s ? 10'd1 : ptr_q;
        cnt_d     = start_s ? 11'd0 : cnt_q;
        odd_d     = start_s ? 1'b0 : odd_q;
        ovf_d     = start_s ? 1'b0 : ovf_q;
        err_d     = start_s ? 1'b0 : err_q;
        held_d    = held_q;
        data_we_s = 1'b0;
        wdat_s    = 16'h0000;
        pend_s    = 1'b0;
        if (rcv_s && eth_rxv_i) begin
            if (cnt_d == CNT_MAX) begin
                ovf_d = 1'b1;
            end else if (!odd_d) begin
                held_d = eth_rxd_i;
                odd_d  = 1'b1;
                cnt_d  = cnt_d + 11'd1;
            end else begin
                data_we_s = 1'b1;
                wdat_s    = {eth_rxd_i, held_d};
                odd_d     = 1'b0;
                cnt_d     = cnt_d + 11'd1;
            end
        end else begin
            held_d = held_q;
        end
        if (rcv_s && eth_eof_i) begin
            err_d  = eth_err_i;
            pend_s = odd_d;
            if (odd_d) begin
                data_we_s = 1'b1;
                wdat_s    = {8'h00, held_d};
                odd_d     = 1'b0;
            end else begin
                data_we_s = data_we_s;
            end
        end else begin
            pend_s = 1'b0;
        end
        wadr_s = ptr_d;
        if (data_we_s && (ptr_d != ADR_MAX)) begin
            ptr_d = ptr_d + 10'd1;
        end else begin
            ptr_d = ptr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d = eth_eof_i ? (pend_s ? S_DRAIN : S_STAT) : S_RECV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RECV: begin
                if (eth_eof_i) begin
                    state_d = pend_s ? S_DRAIN : S_STAT;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_DRAIN: state_d = S_STAT;
            S_STAT: begin
                // Bit 13 of the visible status word is the runt flag.
                if (stat_vis_s) begin
                    state_d = dat_q[13] ? S_IDLE : S_DONE;
                end else begin
                    state_d = S_STAT;
                end
            end
            S_DONE: begin
                if (rx_ena_i) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: status write waits one cycle if a data word occupies the bus.
    always_comb begin
        stat_we_s   = (state_d == S_STAT) && !data_we_s;
        stat_word_s = {err_d, ovf_d, runt_s, 2'b00, cnt_d};
        we_d        = data_we_s || stat_we_s;
        busy_d      = (state_d == S_RECV) || (state_d == S_DRAIN) || (state_d == S_STAT);
        if (stat_we_s) begin
            adr_d  = 10'd0;
            dat_d  = stat_word_s;
            len_d  = cnt_d;
            done_d = !runt_s;
        end else if (data_we_s) begin
            adr_d  = wadr_s;
            dat_d  = wdat_s;
            len_d  = len_q;
            done_d = 1'b0;
        end else begin
            adr_d  = (state_d == S_RECV) ? ptr_d : adr_q;
            dat_d  = dat_q;
            len_d  = len_q;
            done_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge eth_clk_i or posedge eth_rst_i) begin
        if (eth_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge eth_clk_i or posedge eth_rst_i) begin
        if (eth_rst_i) begin
            ptr_q  <= 10'd0;
            cnt_q  <= 11'd0;
            held_q <= 8'h00;
            odd_q  <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            adr_q  <= 10'd0;
            dat_q  <= 16'h0000;
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            len_q  <= 11'd0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            held_q <= held_d;
            odd_q  <= odd_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
            adr_q  <= adr_d;
            dat_q  <= dat_d;
            we_q   <= we_d;
            busy_q <= busy_d;
            done_q <= done_d;
            len_q  <= len_d;
        end
    end

    assign eth_adr_o = adr_q;
    assign eth_dat_o = dat_q;
    assign eth_we_o  = we_q;
    assign busy_o    = busy_q;
    assign rx_done_o = done_q;
    assign rx_len_o  = len_q;
endmodule

// File: tb/tb_rxpack.sv
// tb_rxpack: directed frames into a default rxpack and a MAXW=4 rxpack, with a write-capturing monitor.
module tb_rxpack;
`ifdef RXPACK_RUNT_EN
    localparam bit RUNT = 1'b1;
`else
    localparam bit RUNT = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        rxv = 1'b0, sof = 1'b0, eof = 1'b0, err = 1'b0, ena = 1'b0;
    logic [9:0]  a_adr, b_adr;
    logic [15:0] a_dat, b_dat;
    logic        a_we, b_we, a_busy, b_busy, a_done, b_done;
    logic [10:0] a_len, b_len;
    logic [15:0] mem_a [0:1023];
    logic [15:0] mem_b [0:7];
    logic [9:0]  log_a [0:1023];
    int wr_a = 0, st_a = 0, dn_a = 0, wr_b = 0, st_b = 0;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    rxpack u_dut (
        .eth_clk_i(clk), .eth_rst_i(rst), .eth_rxd_i(rxd), .eth_rxv_i(rxv),
        .eth_sof_i(sof), .eth_eof_i(eof), .eth_err_i(err), .rx_ena_i(ena),
        .eth_adr_o(a_adr), .eth_dat_o(a_dat), .eth_we_o(a_we), .busy_o(a_busy),
        .rx_done_o(a_done), .rx_len_o(a_len)
    );

    rxpack #(.MAXW(4)) u_dut4 (
        .eth_clk_i(clk), .eth_rst_i(rst), .eth_rxd_i(rxd), .eth_rxv_i(rxv),
        .eth_sof_i(sof), .eth_eof_i(eof), .eth_err_i(err), .rx_ena_i(ena),
        .eth_adr_o(b_adr), .eth_dat_o(b_dat), .eth_we_o(b_we), .busy_o(b_busy),
        .rx_done_o(b_done), .rx_len_o(b_len)
    );

    // Capture every buffer write of both instances.
    always @(negedge clk) begin
        if (a_we) begin
            mem_a[a_adr]       <= a_dat;
            log_a[wr_a[9:0]]   <= a_adr;
            wr_a               <= wr_a + 1;
            if (a_adr == 10'd0) st_a <= st_a + 1;
        end
        if (a_done) dn_a <= dn_a + 1;
        if (b_we) begin
            mem_b[b_adr[2:0]] <= b_dat;
            wr_b              <= wr_b + 1;
            if (b_adr == 10'd0) st_b <= st_b + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_stat(input logic e, input logic o, input int len);
        logic r;
        r = RUNT && (len < 60);
        return {e, o, r, 2'b00, 11'(len)};
    endfunction

    function automatic int exp_done(input int len);
        return (RUNT && (len < 60)) ? 0 : 1;
    endfunction

    // Bytes are 00,01,... except byte 64 which is 8'hAB.
    task automatic send_bytes(input int n, input logic e, input logic with_eof);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sof = (i == 0);
            eof = with_eof && (i == n - 1);
            err = with_eof && (i == n - 1) && e;
            rxv = 1'b1;
            rxd = (i < 64) ? 8'(i) : 8'hAB;
        end
        @(negedge clk);
        sof = 1'b0; eof = 1'b0; err = 1'b0; rxv = 1'b0; rxd = 8'h00;
    endtask

    task automatic wait_stat(input int sa, input int sb);
        int c;
        c = 0;
        while ((st_a == sa || st_b == sb) && c < 200) begin
            @(negedge clk);
            c = c + 1;
        end
        check("stat_wait", 32'(c < 200), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic rearm();
        @(negedge clk); ena = 1'b0;
        @(negedge clk); ena = 1'b1;
    endtask

    initial begin
        int sa, sb, wa, wb, da;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_adr", 32'(a_adr), 32'd0);
        check("rst_dat", 32'(a_dat), 32'd0);
        check("rst_we", 32'(a_we), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_len", 32'(a_len), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        // sof while disarmed is dropped
        wa = wr_a;
        send_bytes(4, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("disarmed_wr", 32'(wr_a - wa), 32'd0);
        ena = 1'b1;

        // 64-byte frame
        sa = st_a; sb = st_b; wa = wr_a; wb = wr_b; da = dn_a;
        send_bytes(64, 1'b0, 1'b1);
        wait_stat(sa, sb);
        for (int k = 1; k <= 32; k++) check("f64_word", 32'(mem_a[k]), 32'({8'(2 * k - 1), 8'(2 * k - 2)}));
        check("f64_stat", 32'(mem_a[0]), 32'(exp_stat(1'b0, 1'b0, 64)));
        check("f64_nwr", 32'(wr_a - wa), 32'd33);
        check("f64_done", 32'(dn_a - da), 32'd1);
        check("f64_len", 32'(a_len), 32'd64);
        check("f64_busy", 32'(a_busy), 32'd0);
        check("m4_f64_nwr", 32'(wr_b - wb), 32'd5);
        check("m4_f64_stat", 32'(mem_b[0]), 32'(exp_stat(1'b0, 1'b1, 8)));
        wa = wr_a;
        send_bytes(4, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("done_sof_ign", 32'(wr_a - wa), 32'd0);

        // 65-byte frame ending in AB
        rearm();
        sa = st_a; sb = st_b; da = dn_a;
        send_bytes(65, 1'b0, 1'b1);
        wait_stat(sa, sb);
        check("f65_w32", 32'(mem_a[32]), 32'h3F3E);
        check("f65_w33", 32'(mem_a[33]), 32'h00AB);
        check("f65_stat", 32'(mem_a[0]), 32'(exp_stat(1'b0, 1'b0, 65)));
        check("f65_len", 32'(a_len), 32'd65);
        check("f65_done", 32'(dn_a - da), 32'd1);

        // 12-byte frame: MAXW=4 instance overflows
        rearm();
        sa = st_a; sb = st_b; wb = wr_b; da = dn_a;
        send_bytes(12, 1'b0, 1'b1);
        wait_stat(sa, sb);
        check("m4_f12_nwr", 32'(wr_b - wb), 32'd5);
        check("m4_f12_w1", 32'(mem_b[1]), 32'h0100);
        check("m4_f12_w4", 32'(mem_b[4]), 32'h0706);
        check("m4_f12_stat", 32'(mem_b[0]), 32'(exp_stat(1'b0, 1'b1, 8)));
        check("f12_stat", 32'(mem_a[0]), 32'(exp_stat(1'b0, 1'b0, 12)));
        check("f12_done", 32'(dn_a - da), 32'(exp_done(12)));

        // errored 64-byte frame, then sof in DONE
        rearm();
        sa = st_a; sb = st_b;
        send_bytes(64, 1'b1, 1'b1);
        wait_stat(sa, sb);
        check("ferr_stat", 32'(mem_a[0]), 32'h8040);
        wa = wr_a;
        send_bytes(4, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("ferr_done_ign", 32'(wr_a - wa), 32'd0);
        check("ferr_busy", 32'(a_busy), 32'd0);

        // 20-byte frame, then sof without rearming
        rearm();
        sa = st_a; sb = st_b; da = dn_a;
        send_bytes(20, 1'b0, 1'b1);
        wait_stat(sa, sb);
        check("f20_stat", 32'(mem_a[0]), 32'(exp_stat(1'b0, 1'b0, 20)));
        check("f20_done", 32'(dn_a - da), 32'(exp_done(20)));
        check("f20_busy", 32'(a_busy), 32'd0);
        wa = wr_a;
        send_bytes(64, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("f20_next_nwr", 32'(wr_a - wa), RUNT ? 32'd33 : 32'd0);

        // reset after 10 bytes
        rearm();
        sa = st_a;
        send_bytes(10, 1'b0, 1'b0);
        #1;
        check("pre_rst_we", 32'(a_we), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_we", 32'(a_we), 32'd0);
        check("mid_rst_adr", 32'(a_adr), 32'd0);
        check("mid_rst_busy", 32'(a_busy), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_nostat", 32'(st_a - sa), 32'd0);
        sa = st_a; sb = st_b; wa = wr_a;
        send_bytes(4, 1'b0, 1'b1);
        wait_stat(sa, sb);
        check("post_rst_adr", 32'(log_a[wa[9:0]]), 32'd1);
        check("post_rst_w1", 32'(mem_a[1]), 32'h0100);
        check("post_rst_w2", 32'(mem_a[2]), 32'h0302);
        check("post_rst_stat", 32'(mem_a[0]), 32'(exp_stat(1'b0, 1'b0, 4)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
